// File: rtl/serial_slave_port.sv
// Slave-side endpoint of the serial bus. Deserialises an MSB-first address
// frame (and, for writes, an MSB-first data frame) into a local word memory,
// and serialises the addressed word back to the master for reads.
module serial_slave_port #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic address,
    input  logic data,
    input  logic valid,
    input  logic write_en,
    output logic ready,
    output logic data_out,
    output logic valid_out
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RLAT,
        RDATA
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAT_LAST  = CW'(READ_LATENCY);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_n;
    logic [DATA_WIDTH-1:0]   data_reg, data_n;
    logic                    we_reg, we_n;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic                    load_rd;
    logic                    shift_rd;
    logic                    mem_wr;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    // Next-state and datapath control; RLAT holds one load cycle followed by
    // READ_LATENCY counted cycles so the first read bit lands READ_LATENCY+1
    // edges after the last address bit.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr_reg;
        data_n   = data_reg;
        we_n     = we_reg;
        load_rd  = 1'b0;
        shift_rd = 1'b0;
        mem_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    addr_n  = {addr_reg[ADDR_WIDTH-2:0], address};
                    we_n    = write_en;
                    cnt_n   = CNT_ONE;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (valid) begin
                    addr_n = {addr_reg[ADDR_WIDTH-2:0], address};
                    if (cnt == ADDR_LAST) begin
                        cnt_n   = '0;
                        state_n = we_reg ? WDATA : RLAT;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            WDATA: begin
                if (valid) begin
                    data_n = {data_reg[DATA_WIDTH-2:0], data};
                    if (cnt == DATA_LAST) begin
                        cnt_n   = '0;
                        state_n = WRITE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            WRITE: begin
                mem_wr  = 1'b1;
                state_n = IDLE;
            end
            RLAT: begin
                if (cnt == '0) begin
                    load_rd = 1'b1;
                end
                if (cnt == LAT_LAST) begin
                    cnt_n   = '0;
                    state_n = RDATA;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            RDATA: begin
                shift_rd = 1'b1;
                if (cnt == DATA_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and shift registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_reg <= '0;
            data_reg <= '0;
            we_reg   <= 1'b0;
            rd_shift <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            addr_reg <= addr_n;
            data_reg <= data_n;
            we_reg   <= we_n;
            if (load_rd) begin
                rd_shift <= mem[addr_reg];
            end else if (shift_rd) begin
                rd_shift <= {rd_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Word memory is never cleared; a reset landing on WRITE cancels the store.
    always_ff @(posedge clk) begin
        if (mem_wr && !reset) begin
            mem[addr_reg] <= data_reg;
        end
    end

    assign ready     = (state == IDLE);
    assign valid_out = (state == RDATA);
    assign data_out  = valid_out & rd_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: writes and reads through the serial
// slave lane with hand-computed expected words, latencies and handshakes.
module tb_serial_slave_port;

    logic clk;
    logic reset;
    logic address;
    logic data;
    logic valid;
    logic write_en;
    logic ready;
    logic data_out;
    logic valid_out;

    int total;
    int bad;

    logic [7:0] got;
    int         n;

    serial_slave_port dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data      (data),
        .valid     (valid),
        .write_en  (write_en),
        .ready     (ready),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one set of inputs for one rising edge, then settle past it.
    task automatic applyStimulus(input logic a, input logic d, input logic v, input logic w);
        address  = a;
        data     = d;
        valid    = v;
        write_en = w;
        @(posedge clk);
        #1;
    endtask

    task automatic gapCycles();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("gap_busy", {31'd0, ready}, 32'd0);
    endtask

    // Full write frame; ends on the first IDLE cycle after WRITE.
    task automatic writeWord(input logic [11:0] a, input logic [7:0] d,
                             input int gap_a, input int gap_d, input logic abort);
        for (int i = 11; i >= 0; i--) begin
            applyStimulus(a[i], 1'b0, 1'b1, 1'b1);
            if (12 - i == gap_a) gapCycles();
        end
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(~a[0], d[i], 1'b1, 1'b0);
            if (8 - i == gap_d) gapCycles();
        end
        valid = 1'b0;
        checkOutput("wr_busy_in_write", {31'd0, ready}, 32'd0);
        reset = abort;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("wr_done_ready", {31'd0, ready}, 32'd1);
    endtask

    // Full read frame; optional valid pulses during RLAT and RDATA.
    task automatic readWord(input logic [11:0] a, input logic noise, output logic [7:0] word);
        int lat;
        int nbits;
        int rdy;
        for (int i = 11; i >= 0; i--) begin
            applyStimulus(a[i], 1'b0, 1'b1, 1'b0);
            if (i == 11) checkOutput("rd_started", {31'd0, ready}, 32'd0);
        end
        valid = 1'b0;
        lat = 0;
        rdy = 0;
        while (valid_out !== 1'b1 && lat < 20) begin
            if (ready === 1'b1) rdy++;
            lat++;
            applyStimulus(1'b1, 1'b1, noise && (lat == 2), 1'b1);
        end
        checkOutput("rd_latency", lat, 32'd3);
        nbits = 0;
        word  = 8'h00;
        while (valid_out === 1'b1 && nbits < 20) begin
            word = {word[6:0], data_out};
            if (ready === 1'b1) rdy++;
            nbits++;
            applyStimulus(1'b1, 1'b0, noise && (nbits == 4), 1'b0);
        end
        valid = 1'b0;
        checkOutput("rd_len", nbits, 32'd8);
        checkOutput("rd_ready_while_busy", rdy, 32'd0);
        checkOutput("rd_done_ready", {31'd0, ready}, 32'd1);
    endtask

    // Directed sequence covering reset, writes, reads, gaps, busy pulses and aborts.
    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        address  = 1'b0;
        data     = 1'b0;
        valid    = 1'b0;
        write_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd1);
        checkOutput("reset_valid_out", {31'd0, valid_out}, 32'd0);
        checkOutput("reset_data_out", {31'd0, data_out}, 32'd0);
        reset = 1'b0;

        $display("[TB] reset after 5 address bits");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("midframe_busy", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("midframe_ready", {31'd0, ready}, 32'd1);
        checkOutput("midframe_valid_out", {31'd0, valid_out}, 32'd0);
        readWord(12'h000, 1'b0, got);

        $display("[TB] basic write/read 0x3C1");
        writeWord(12'h3C1, 8'hA5, -1, -1, 1'b0);
        readWord(12'h3C1, 1'b0, got);
        checkOutput("basic_3C1", {24'd0, got}, 32'h0000_00A5);

        $display("[TB] gapped write 0x001");
        writeWord(12'h001, 8'h5A, 4, 6, 1'b0);
        readWord(12'h001, 1'b0, got);
        checkOutput("gapped_001", {24'd0, got}, 32'h0000_005A);

        $display("[TB] busy rejection on 0xFFF");
        writeWord(12'hFFF, 8'h81, -1, -1, 1'b0);
        readWord(12'hFFF, 1'b1, got);
        checkOutput("busy_FFF", {24'd0, got}, 32'h0000_0081);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("busy_no_new_frame", {31'd0, ready}, 32'd1);
        checkOutput("busy_no_valid_out", {31'd0, valid_out}, 32'd0);

        $display("[TB] boundary addresses");
        writeWord(12'h000, 8'hFF, -1, -1, 1'b0);
        writeWord(12'hFFF, 8'h01, -1, -1, 1'b0);
        readWord(12'h000, 1'b0, got);
        checkOutput("bound_000", {24'd0, got}, 32'h0000_00FF);
        readWord(12'hFFF, 1'b0, got);
        checkOutput("bound_FFF", {24'd0, got}, 32'h0000_0001);
        readWord(12'h001, 1'b0, got);
        checkOutput("bound_001_kept", {24'd0, got}, 32'h0000_005A);

        $display("[TB] back-to-back read after write");
        writeWord(12'h3C1, 8'h3C, -1, -1, 1'b0);
        readWord(12'h3C1, 1'b0, got);
        checkOutput("b2b_3C1", {24'd0, got}, 32'h0000_003C);

        $display("[TB] reset during WRITE cancels store");
        writeWord(12'h3C1, 8'h77, -1, -1, 1'b1);
        readWord(12'h3C1, 1'b0, got);
        checkOutput("abort_keeps_3C1", {24'd0, got}, 32'h0000_003C);

        $display("[TB] reset during RDATA");
        for (int i = 11; i >= 0; i--) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        valid = 1'b0;
        n = 0;
        while (valid_out !== 1'b1 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("rdata_reset_latency", n, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rdata_mid_valid", {31'd0, valid_out}, 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("rdata_reset_valid_out", {31'd0, valid_out}, 32'd0);
        checkOutput("rdata_reset_ready", {31'd0, ready}, 32'd1);
        readWord(12'hFFF, 1'b0, got);
        checkOutput("after_reset_FFF", {24'd0, got}, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
